// File: rtl/div_serial.sv
`timescale 1ns/1ps
// div_serial
//   Sequential unsigned restoring divider, one quotient bit per clock.
//   Produces floor(dividend/divisor) and dividend mod divisor for the
//   downstream fractional divider.
//
// Ports
//   clk         clock, all state on rising edge
//   rst         asynchronous, active-low reset
//   start       request a division (taken when idle, or on the DONE cycle)
//   dividend    unsigned numerator, captured on the accepting edge
//   divisor     unsigned denominator, captured on the accepting edge
//   ready       block idle, start will be accepted
//   done        one-cycle pulse, results valid this cycle and held afterwards
//   quotient    floor(dividend/divisor); all-ones when divisor=0
//   remainder   dividend mod divisor; equals dividend when divisor=0
//   div_by_zero last completed division had divisor=0
module div_serial #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              ready,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder,
   output logic              div_by_zero
);

   localparam int unsigned CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] sh;      // dividend bits shift out of the top, quotient bits in at the bottom
   logic [DATA_W-1:0] dsr;
   logic [DATA_W-1:0] r;       // partial remainder; always < divisor so DATA_W bits hold it
   logic              zflag;

   logic [DATA_W:0]   r_sh;
   logic [DATA_W-1:0] r_diff;
   logic              ge;
   logic [DATA_W-1:0] r_nxt;
   logic [DATA_W-1:0] q_nxt;

   // One restoring step. The compare is DATA_W+1 wide; the low DATA_W bits
   // of the difference are all that survive when the subtraction is taken.
   always_comb begin
      r_sh   = {r, sh[DATA_W-1]};
      r_diff = r_sh[DATA_W-1:0] - dsr;
      ge     = (r_sh >= {1'b0, dsr});
      r_nxt  = ge ? r_diff : r_sh[DATA_W-1:0];
      q_nxt  = {sh[DATA_W-2:0], ge};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         sh          <= '0;
         dsr         <= '0;
         r           <= '0;
         zflag       <= 1'b0;
         ready       <= 1'b1;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sh    <= dividend;
                  dsr   <= divisor;
                  r     <= '0;
                  cnt   <= '0;
                  zflag <= (divisor == '0);
                  ready <= 1'b0;
                  state <= RUN;
               end
            end
            RUN: begin
               sh  <= q_nxt;
               r   <= r_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == LAST_ITER) begin
                  cnt         <= '0;
                  done        <= 1'b1;
                  quotient    <= q_nxt;
                  remainder   <= r_nxt;
                  div_by_zero <= zflag;
                  state       <= DONE;
               end
            end
            DONE: begin
               done <= 1'b0;
               // A start held through DONE is taken on the edge leaving it,
               // so back-to-back divisions run every DATA_W+1 cycles.
               if (start) begin
                  sh    <= dividend;
                  dsr   <= divisor;
                  r     <= '0;
                  cnt   <= '0;
                  zflag <= (divisor == '0);
                  state <= RUN;
               end else begin
                  ready <= 1'b1;
                  state <= IDLE;
               end
            end
            default: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_serial.sv
`timescale 1ns/1ps
// tb_div_serial
//   Directed and back-to-back random checks of div_serial at DATA_W=32.
module tb_div_serial;

   localparam int unsigned W = 32;
   localparam int unsigned LAT = W + 1;
   localparam int unsigned N_RAND = 2000;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         ready;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   div_serial #(.DATA_W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .ready       (ready),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   // Stimulus only: issue one division from idle and return the number of
   // cycles from the accepting edge to the cycle where done is seen.
   task automatic run_div(input logic [W-1:0] dd, input logic [W-1:0] ds, output int lat);
      @(negedge clk);
      dividend = dd;
      divisor  = ds;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      while (done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst      = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #12;
      vecs++; if (ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b expected 1", ready); end
      vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b expected 0", done); end
      vecs++; if (quotient !== 32'h0) begin errs++; $display("FAIL reset_q: got %h expected 0", quotient); end
      vecs++; if (remainder !== 32'h0) begin errs++; $display("FAIL reset_r: got %h expected 0", remainder); end
      vecs++; if (div_by_zero !== 1'b0) begin errs++; $display("FAIL reset_dz: got %b expected 0", div_by_zero); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic();
      int lat;
      int ready_low;
      @(negedge clk);
      dividend = 32'd48000;
      divisor  = 32'd44100;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start     = 1'b0;
      lat       = 1;
      ready_low = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (ready === 1'b0) ready_low++;
         @(negedge clk);
         lat++;
      end
      if (ready === 1'b0) ready_low++;
      vecs++; if (lat != 33) begin errs++; $display("FAIL basic_latency: got %0d expected 33", lat); end
      vecs++; if (quotient !== 32'd1) begin errs++; $display("FAIL basic_q: got %0d expected 1", quotient); end
      vecs++; if (remainder !== 32'd3900) begin errs++; $display("FAIL basic_r: got %0d expected 3900", remainder); end
      vecs++; if (div_by_zero !== 1'b0) begin errs++; $display("FAIL basic_dz: got %b expected 0", div_by_zero); end
      vecs++; if (ready_low != 33) begin errs++; $display("FAIL basic_ready_low: got %0d cycles expected 33", ready_low); end
      @(negedge clk);
      vecs++; if (done !== 1'b0) begin errs++; $display("FAIL basic_done_width: got %b expected 0", done); end
      vecs++; if (ready !== 1'b1) begin errs++; $display("FAIL basic_ready_back: got %b expected 1", ready); end
      vecs++; if (quotient !== 32'd1 || remainder !== 32'd3900) begin
         errs++; $display("FAIL basic_hold: got %0d/%0d expected 1/3900", quotient, remainder);
      end
   endtask

   task automatic test_extremes();
      logic [W-1:0] dd [3];
      logic [W-1:0] ds [3];
      logic [W-1:0] eq [3];
      logic [W-1:0] er [3];
      int lat;
      dd[0] = 32'hFFFF_FFFF; ds[0] = 32'd1; eq[0] = 32'hFFFF_FFFF; er[0] = 32'd0;
      dd[1] = 32'd5;         ds[1] = 32'd9; eq[1] = 32'd0;         er[1] = 32'd5;
      dd[2] = 32'd0;         ds[2] = 32'd7; eq[2] = 32'd0;         er[2] = 32'd0;
      for (int i = 0; i < 3; i++) begin
         run_div(dd[i], ds[i], lat);
         vecs++;
         if (lat != 33 || quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0) begin
            errs++;
            $display("FAIL extreme_%0d: got q=%h r=%h dz=%b lat=%0d expected q=%h r=%h dz=0 lat=33",
                     i, quotient, remainder, div_by_zero, lat, eq[i], er[i]);
         end
      end
   endtask

   task automatic test_div_zero();
      int lat;
      run_div(32'd7, 32'd0, lat);
      vecs++; if (lat != 33) begin errs++; $display("FAIL dz_latency: got %0d expected 33", lat); end
      vecs++; if (quotient !== 32'hFFFF_FFFF) begin errs++; $display("FAIL dz_q: got %h expected ffffffff", quotient); end
      vecs++; if (remainder !== 32'd7) begin errs++; $display("FAIL dz_r: got %0d expected 7", remainder); end
      vecs++; if (div_by_zero !== 1'b1) begin errs++; $display("FAIL dz_flag: got %b expected 1", div_by_zero); end
      repeat (3) @(negedge clk);
      vecs++; if (div_by_zero !== 1'b1) begin errs++; $display("FAIL dz_flag_hold: got %b expected 1", div_by_zero); end
      run_div(32'd10, 32'd3, lat);
      vecs++;
      if (lat != 33 || quotient !== 32'd3 || remainder !== 32'd1 || div_by_zero !== 1'b0) begin
         errs++;
         $display("FAIL dz_followup: got q=%0d r=%0d dz=%b lat=%0d expected q=3 r=1 dz=0 lat=33",
                  quotient, remainder, div_by_zero, lat);
      end
   endtask

   task automatic test_busy();
      int dones;
      int dcyc;
      logic [W-1:0] q_at;
      logic [W-1:0] r_at;
      dones = 0;
      dcyc  = 0;
      q_at  = '0;
      r_at  = '0;
      @(negedge clk);
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= 45; cyc++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            dones++;
            dcyc = cyc;
            q_at = quotient;
            r_at = remainder;
         end
         if (cyc == 5 || cyc == 20) begin
            start    = 1'b1;
            dividend = 32'd9;
            divisor  = 32'd3;
         end else if (cyc < 30) begin
            start    = 1'b0;
            dividend = 32'h1234_0000 + 32'(cyc);
            divisor  = 32'(cyc);
         end else begin
            start = 1'b0;
         end
      end
      vecs++; if (dones != 1) begin errs++; $display("FAIL busy_done_count: got %0d expected 1", dones); end
      vecs++; if (dcyc != 33) begin errs++; $display("FAIL busy_done_cycle: got %0d expected 33", dcyc); end
      vecs++; if (q_at !== 32'd14 || r_at !== 32'd2) begin
         errs++; $display("FAIL busy_result: got %0d/%0d expected 14/2", q_at, r_at);
      end
      vecs++; if (quotient !== 32'd14 || ready !== 1'b1) begin
         errs++; $display("FAIL busy_hold: got q=%0d ready=%b expected q=14 ready=1", quotient, ready);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      @(negedge clk);
      dividend = 32'd1000;
      divisor  = 32'd3;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      vecs++; if (ready !== 1'b1 || done !== 1'b0) begin
         errs++; $display("FAIL midrst_ctrl: got ready=%b done=%b expected ready=1 done=0", ready, done);
      end
      vecs++; if (quotient !== 32'h0 || remainder !== 32'h0 || div_by_zero !== 1'b0) begin
         errs++; $display("FAIL midrst_outputs: got q=%h r=%h dz=%b expected all zero", quotient, remainder, div_by_zero);
      end
      @(negedge clk);
      rst = 1'b1;
      run_div(32'd9, 32'd4, lat);
      vecs++;
      if (lat != 33 || quotient !== 32'd2 || remainder !== 32'd1 || div_by_zero !== 1'b0) begin
         errs++;
         $display("FAIL midrst_after: got q=%0d r=%0d dz=%b lat=%0d expected q=2 r=1 dz=0 lat=33",
                  quotient, remainder, div_by_zero, lat);
      end
   endtask

   task automatic gen_pair(output logic [W-1:0] dd, output logic [W-1:0] ds);
      dd = $urandom;
      if ($urandom_range(3) == 0) dd = dd >> $urandom_range(31);
      if ($urandom_range(99) < 5) begin
         ds = '0;
      end else begin
         ds = $urandom;
         ds = ds >> $urandom_range(31);
         if (ds == '0) ds = 32'd1;
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] cd, cs, nd, ns;
      logic [W-1:0] eq, er;
      logic         ez;
      int lat;
      gen_pair(cd, cs);
      @(negedge clk);
      dividend = cd;
      divisor  = cs;
      start    = 1'b1;
      @(posedge clk);
      for (int i = 0; i < N_RAND; i++) begin
         gen_pair(nd, ns);
         @(negedge clk);
         if (i < N_RAND - 1) begin
            dividend = nd;
            divisor  = ns;
         end else begin
            start = 1'b0;
         end
         lat = 1;
         while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
         end
         if (cs == '0) begin
            eq = '1;
            er = cd;
            ez = 1'b1;
         end else begin
            eq = cd / cs;
            er = cd % cs;
            ez = 1'b0;
         end
         vecs++;
         if (lat != 33 || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            errs++;
            $display("FAIL b2b_%0d: %h/%h got q=%h r=%h dz=%b spacing=%0d expected q=%h r=%h dz=%b spacing=33",
                     i, cd, cs, quotient, remainder, div_by_zero, lat, eq, er, ez);
            if (lat >= 100) begin
               start = 1'b0;
               break;
            end
         end
         cd = nd;
         cs = ns;
      end
      start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_div_zero();
      test_busy();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vecs, errs);
      $fatal(1, "timeout");
   end

endmodule
